// File: rtl/motor_pkg.sv
// Shared types and widths for the stepper segment queue.
// A segment is {direction, step count, step period}.
package motor_pkg;

  localparam int STEPS_W = 13;
  localparam int DIV_W   = 15;
  localparam int DIR_BIT = 12;
  localparam int CNT_W   = 12;

  typedef struct packed {
    logic             dir;
    logic [CNT_W-1:0] steps;
    logic [DIV_W-1:0] divider;
  } seg_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } run_state_e;

  function automatic logic [DIV_W-1:0] clamp_div(input logic [DIV_W-1:0] div,
                                                 input logic [DIV_W-1:0] min_div);
    return (div < min_div) ? min_div : div;
  endfunction

endpackage

// File: rtl/motor_segment_queue_seg_fifo.sv
// Single-clock segment FIFO with occupancy count, sticky overflow and a
// registered head output (head_o is valid the cycle after any pointer change).
module seg_fifo
  import motor_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  seg_t                     push_data_i,
  input  logic                     pop_i,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     overflow_o,
  output logic                     head_valid_o,
  output seg_t                     head_o
);

  localparam int AW = $clog2(DEPTH);

  seg_t          mem [DEPTH];
  seg_t          head_q;
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d;
  logic          overflow_q, head_valid_q;
  logic          do_push, do_pop;

  assign empty_o  = (count_q == '0);
  assign full_o   = (count_q == (AW+1)'(DEPTH));
  assign do_pop   = pop_i & ~empty_o;
  // A full FIFO still accepts a write when a pop frees the slot in the same cycle.
  assign do_push  = push_i & (~full_o | do_pop);

  always_comb begin
    count_d = count_q;
    if (do_push & ~do_pop)      count_d = count_q + (AW+1)'(1);
    else if (do_pop & ~do_push) count_d = count_q - (AW+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= push_data_i;
    head_q <= mem[rd_ptr_q];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      overflow_q   <= 1'b0;
      head_valid_q <= 1'b0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
      if (push_i & full_o & ~do_pop) overflow_q <= 1'b1;
      head_valid_q <= ~empty_o;
    end
  end

  assign level_o      = count_q;
  assign overflow_o   = overflow_q;
  assign head_valid_o = head_valid_q;
  assign head_o       = head_q;

endmodule

// File: rtl/motor_segment_queue.sv
// Segment queue feeding one step generator: clamps/drops writes, pops on the
// generator's active rising edge, and tracks absolute position from step pulses.
module motor_segment_queue
  import motor_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int MIN_DIVIDER = 8,
  parameter int POS_W       = 19
) (
  input  logic                    CLK,
  input  logic                    reset_n,
  input  logic                    wr_en,
  input  logic [STEPS_W-1:0]      wr_steps,
  input  logic [DIV_W-1:0]        wr_divider,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  level,
  output logic                    overflow,
  output logic [STEPS_W-1:0]      stepsToGo,
  output logic [DIV_W-1:0]        divider,
  input  logic                    motor_active,
  input  logic                    motor_step,
  input  logic                    motor_dir,
  input  logic                    pos_clear,
  output logic signed [POS_W-1:0] position,
  output logic                    busy,
  output logic                    running
);

  localparam logic [DIV_W-1:0] MIN_DIV = DIV_W'(MIN_DIVIDER);

  seg_t                    wr_seg, head;
  logic                    push, pop_req, head_valid;
  logic                    act_q, step_q, running_q;
  logic signed [POS_W-1:0] pos_q, pos_d;
  run_state_e              state_q;

  // Zero-step segments are dropped: the generator would re-latch every cycle.
  assign push    = wr_en & (wr_steps[CNT_W-1:0] != '0);
  assign pop_req = motor_active & ~act_q;

  always_comb begin
    wr_seg.dir     = wr_steps[DIR_BIT];
    wr_seg.steps   = wr_steps[CNT_W-1:0];
    wr_seg.divider = clamp_div(wr_divider, MIN_DIV);
  end

  seg_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk          (CLK),
    .rst_n        (reset_n),
    .push_i       (push),
    .push_data_i  (wr_seg),
    .pop_i        (pop_req),
    .full_o       (full),
    .empty_o      (empty),
    .level_o      (level),
    .overflow_o   (overflow),
    .head_valid_o (head_valid),
    .head_o       (head)
  );

  assign stepsToGo = head_valid ? {head.dir, head.steps} : '0;
  assign divider   = head_valid ? head.divider : MIN_DIV;
  assign busy      = ~empty | motor_active;
  assign running   = running_q;
  assign position  = pos_q;

  always_comb begin
    pos_d = pos_q;
    if (pos_clear)
      pos_d = '0;
    else if (motor_step & ~step_q)
      pos_d = motor_dir ? pos_q + POS_W'(1) : pos_q - POS_W'(1);
  end

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      act_q  <= 1'b0;
      step_q <= 1'b0;
      pos_q  <= '0;
    end else begin
      act_q  <= motor_active;
      step_q <= motor_step;
      pos_q  <= pos_d;
    end
  end

  // RUN holds until the queue is drained and the generator has gone quiet.
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      running_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: if (~empty) begin
          state_q   <= ST_RUN;
          running_q <= 1'b1;
        end
        ST_RUN: if (empty & ~motor_active & ~act_q) begin
          state_q   <= ST_IDLE;
          running_q <= 1'b0;
        end
        default: begin
          state_q   <= ST_IDLE;
          running_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_motor_segment_queue.sv
// Self-checking bench: directed vector table, hand sequences for fill/overflow
// and reset, then randomized traffic against a queue-based reference model.
module tb_motor_segment_queue;
  import motor_pkg::*;

  localparam int DEPTH = 16;
  localparam int MIN_D = 8;
  localparam int POS_W = 19;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic                    CLK = 1'b0;
  logic                    reset_n = 1'b0;
  logic                    wr_en = 1'b0;
  logic [12:0]             wr_steps = '0;
  logic [14:0]             wr_divider = '0;
  logic                    full, empty, overflow, busy, running;
  logic [LW-1:0]           level;
  logic [12:0]             stepsToGo;
  logic [14:0]             divider;
  logic                    motor_active = 1'b0, motor_step = 1'b0, motor_dir = 1'b0, pos_clear = 1'b0;
  logic signed [POS_W-1:0] position;

  motor_segment_queue #(.DEPTH(DEPTH), .MIN_DIVIDER(MIN_D), .POS_W(POS_W)) dut (
    .CLK(CLK), .reset_n(reset_n), .wr_en(wr_en), .wr_steps(wr_steps), .wr_divider(wr_divider),
    .full(full), .empty(empty), .level(level), .overflow(overflow),
    .stepsToGo(stepsToGo), .divider(divider),
    .motor_active(motor_active), .motor_step(motor_step), .motor_dir(motor_dir),
    .pos_clear(pos_clear), .position(position), .busy(busy), .running(running)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // One clock: apply inputs, take the edge, sample 1 time unit later.
  task automatic drive(input logic we, input logic [12:0] st, input logic [14:0] dv,
                       input logic ma, input logic ms, input logic md, input logic pc);
    wr_en = we; wr_steps = st; wr_divider = dv;
    motor_active = ma; motor_step = ms; motor_dir = md; pos_clear = pc;
    @(posedge CLK);
    #1;
  endtask

  // ---------------- reference model ----------------
  seg_t                    mq[$];
  logic                    act_m, step_m, ovf_m, run_m;
  logic signed [POS_W-1:0] pos_m;
  logic                    e_valid;
  seg_t                    e_head;

  task automatic model_reset();
    mq.delete();
    act_m = 0; step_m = 0; ovf_m = 0; run_m = 0; pos_m = '0;
  endtask

  task automatic model_step(input logic we, input logic [12:0] st, input logic [14:0] dv,
                            input logic ma, input logic ms, input logic md, input logic pc);
    int   sz;
    logic pop, wr_ok;
    seg_t s;
    sz      = mq.size();
    e_valid = (sz != 0);
    if (e_valid) e_head = mq[0];
    pop   = ma && !act_m && sz != 0;
    wr_ok = we && (st[11:0] != 0);
    if (wr_ok && sz == DEPTH && !pop) ovf_m = 1;
    if (!run_m) run_m = (sz != 0);
    else if (sz == 0 && !ma && !act_m) run_m = 0;
    if (pop) void'(mq.pop_front());
    if (wr_ok && (sz < DEPTH || pop)) begin
      s.dir = st[12]; s.steps = st[11:0];
      s.divider = (dv < MIN_D) ? 15'(MIN_D) : dv;
      mq.push_back(s);
    end
    if (pc) pos_m = '0;
    else if (ms && !step_m) pos_m = md ? pos_m + 19'sd1 : pos_m - 19'sd1;
    act_m  = ma;
    step_m = ms;
  endtask

  task automatic model_check();
    chk("r_stg", 32'(stepsToGo), e_valid ? 32'({e_head.dir, e_head.steps}) : 32'd0);
    chk("r_div", 32'(divider), e_valid ? 32'(e_head.divider) : 32'(MIN_D));
    chk("r_level", 32'(level), 32'(mq.size()));
    chk("r_full", 32'(full), 32'(mq.size() == DEPTH));
    chk("r_empty", 32'(empty), 32'(mq.size() == 0));
    chk("r_ovf", 32'(overflow), 32'(ovf_m));
    chk("r_pos", 32'(position), 32'(pos_m));
    chk("r_busy", 32'(busy), 32'(mq.size() != 0 || motor_active));
    chk("r_running", 32'(running), 32'(run_m));
  endtask

  task automatic do_reset();
    reset_n = 0;
    wr_en = 0; wr_steps = '0; wr_divider = '0;
    motor_active = 0; motor_step = 0; motor_dir = 0; pos_clear = 0;
    @(negedge CLK);
    chk("rst_level", 32'(level), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_ovf", 32'(overflow), 0);
    chk("rst_stg", 32'(stepsToGo), 0);
    chk("rst_div", 32'(divider), 32'(MIN_D));
    chk("rst_pos", 32'(position), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_running", 32'(running), 0);
    @(negedge CLK);
    reset_n = 1;
    @(posedge CLK);
    #1;
    model_reset();
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic                    we;
    logic [12:0]             st;
    logic [14:0]             dv;
    logic                    ma, ms, md, pc;
    logic [12:0]             e_stg;
    logic [14:0]             e_div;
    logic [LW-1:0]           e_lvl;
    logic                    e_empty;
    logic signed [POS_W-1:0] e_pos;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic we, input logic [12:0] st, input logic [14:0] dv,
                              input logic ma, input logic ms, input logic md, input logic pc,
                              input logic [12:0] es, input logic [14:0] ed, input int el,
                              input logic ee, input int ep);
    vec_t v;
    v.we = we; v.st = st; v.dv = dv; v.ma = ma; v.ms = ms; v.md = md; v.pc = pc;
    v.e_stg = es; v.e_div = ed; v.e_lvl = LW'(el); v.e_empty = ee; v.e_pos = POS_W'(ep);
    return v;
  endfunction

  logic        we_r, ma_r, ms_r, md_r, pc_r;
  logic [12:0] st_r;
  logic [14:0] dv_r;
  int          p_act, p_wr;

  initial begin
    // write, pop on active edge, hold active, drop zero-step, clamp divider, pop while empty
    vecs.push_back(mk(0, 13'h0000,   0, 0,0,0,0, 13'h0000,   8, 0, 1, 0));
    vecs.push_back(mk(1, 13'h1005, 100, 0,0,0,0, 13'h0000,   8, 1, 0, 0));
    vecs.push_back(mk(0, 13'h0000,   0, 0,0,0,0, 13'h1005, 100, 1, 0, 0));
    vecs.push_back(mk(1, 13'h0007, 200, 0,0,0,0, 13'h1005, 100, 2, 0, 0));
    vecs.push_back(mk(0, 13'h0000,   0, 0,0,0,0, 13'h1005, 100, 2, 0, 0));
    vecs.push_back(mk(0, 13'h0000,   0, 1,0,0,0, 13'h1005, 100, 1, 0, 0));
    vecs.push_back(mk(0, 13'h0000,   0, 1,0,0,0, 13'h0007, 200, 1, 0, 0));
    vecs.push_back(mk(0, 13'h0000,   0, 1,0,0,0, 13'h0007, 200, 1, 0, 0));
    vecs.push_back(mk(0, 13'h0000,   0, 0,0,0,0, 13'h0007, 200, 1, 0, 0));
    vecs.push_back(mk(1, 13'h1000,  50, 0,0,0,0, 13'h0007, 200, 1, 0, 0));
    vecs.push_back(mk(1, 13'h0003,   3, 0,0,0,0, 13'h0007, 200, 2, 0, 0));
    vecs.push_back(mk(0, 13'h0000,   0, 1,0,0,0, 13'h0007, 200, 1, 0, 0));
    vecs.push_back(mk(0, 13'h0000,   0, 0,0,0,0, 13'h0003,   8, 1, 0, 0));
    vecs.push_back(mk(0, 13'h0000,   0, 1,0,0,0, 13'h0003,   8, 0, 1, 0));
    vecs.push_back(mk(0, 13'h0000,   0, 0,0,0,0, 13'h0000,   8, 0, 1, 0));
    vecs.push_back(mk(0, 13'h0000,   0, 1,0,0,0, 13'h0000,   8, 0, 1, 0));
    vecs.push_back(mk(0, 13'h0000,   0, 0,0,0,0, 13'h0000,   8, 0, 1, 0));
    // position: 10 reverse steps, 3 forward, clear beats a coincident step, then +1
    for (int i = 0; i < 10; i++) begin
      vecs.push_back(mk(0, 0, 0, 0,1,0,0, 0, 8, 0, 1, -(i+1)));
      vecs.push_back(mk(0, 0, 0, 0,0,0,0, 0, 8, 0, 1, -(i+1)));
    end
    for (int i = 0; i < 3; i++) begin
      vecs.push_back(mk(0, 0, 0, 0,1,1,0, 0, 8, 0, 1, -9+i));
      vecs.push_back(mk(0, 0, 0, 0,0,1,0, 0, 8, 0, 1, -9+i));
    end
    vecs.push_back(mk(0, 0, 0, 0,1,1,1, 0, 8, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0,0,1,0, 0, 8, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0,1,1,0, 0, 8, 0, 1, 1));

    do_reset();
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].we, vecs[i].st, vecs[i].dv, vecs[i].ma, vecs[i].ms, vecs[i].md, vecs[i].pc);
      $display("vec %0d: stg=%h div=%0d level=%0d empty=%0d pos=%0d",
               i, stepsToGo, divider, level, empty, position);
      chk($sformatf("v%0d_stg", i), 32'(stepsToGo), 32'(vecs[i].e_stg));
      chk($sformatf("v%0d_div", i), 32'(divider), 32'(vecs[i].e_div));
      chk($sformatf("v%0d_level", i), 32'(level), 32'(vecs[i].e_lvl));
      chk($sformatf("v%0d_empty", i), 32'(empty), 32'(vecs[i].e_empty));
      chk($sformatf("v%0d_pos", i), 32'(position), 32'(vecs[i].e_pos));
      chk($sformatf("v%0d_ovf", i), 32'(overflow), 0);
    end

    // fill to DEPTH, zero-step write while full, overflow, write+pop while full
    do_reset();
    for (int i = 0; i < DEPTH; i++) drive(1, 13'(i+1), 15'(20+i), 0,0,0,0);
    $display("fill: level=%0d full=%0d ovf=%0d", level, full, overflow);
    chk("fill_level", 32'(level), DEPTH);
    chk("fill_full", 32'(full), 1);
    chk("fill_ovf", 32'(overflow), 0);
    drive(1, 13'h0000, 9, 0,0,0,0);
    chk("zero_when_full_ovf", 32'(overflow), 0);
    drive(1, 13'h0abc, 30, 0,0,0,0);
    $display("overflow write: level=%0d ovf=%0d", level, overflow);
    chk("ovf_set", 32'(overflow), 1);
    chk("ovf_level", 32'(level), DEPTH);
    drive(1, 13'h0011, 40, 1,0,0,0);
    $display("write+pop full: level=%0d full=%0d", level, full);
    chk("wrpop_level", 32'(level), DEPTH);
    chk("wrpop_full", 32'(full), 1);
    drive(0, 0, 0, 0,0,0,0);
    chk("wrpop_head_stg", 32'(stepsToGo), 32'h0002);
    chk("wrpop_head_div", 32'(divider), 21);
    for (int i = 0; i < DEPTH-1; i++) begin
      drive(0, 0, 0, 1,0,0,0);
      drive(0, 0, 0, 0,0,0,0);
    end
    $display("drain: level=%0d stg=%h div=%0d", level, stepsToGo, divider);
    chk("drain_level", 32'(level), 1);
    chk("drain_last_stg", 32'(stepsToGo), 32'h0011);
    chk("drain_last_div", 32'(divider), 40);
    chk("ovf_sticky", 32'(overflow), 1);

    // asynchronous reset mid-run with 4 queued segments
    do_reset();
    for (int i = 0; i < 4; i++) drive(1, 13'(i+1), 50, 0,0,0,0);
    drive(0, 0, 0, 0,1,1,0);
    drive(0, 0, 0, 0,0,1,0);
    drive(0, 0, 0, 0,1,1,0);
    chk("pre_rst_level", 32'(level), 4);
    chk("pre_rst_pos", 32'(position), 2);
    chk("pre_rst_stg", 32'(stepsToGo), 32'h0001);
    #3;
    reset_n = 0;
    #1;
    $display("async reset: empty=%0d stg=%h pos=%0d level=%0d", empty, stepsToGo, position, level);
    chk("arst_empty", 32'(empty), 1);
    chk("arst_stg", 32'(stepsToGo), 0);
    chk("arst_pos", 32'(position), 0);
    chk("arst_level", 32'(level), 0);
    chk("arst_div", 32'(divider), 32'(MIN_D));

    // randomized traffic, alternating fill-heavy and drain-heavy phases
    do_reset();
    for (int blk = 0; blk < 8; blk++) begin
      p_act = (blk % 2 == 0) ? 10 : 60;
      p_wr  = (blk % 2 == 0) ? 70 : 25;
      for (int c = 0; c < 400; c++) begin
        we_r = ($urandom_range(0, 99) < p_wr);
        st_r = 13'($urandom);
        if ($urandom_range(0, 7) == 0) st_r[11:0] = '0;
        dv_r = ($urandom_range(0, 3) == 0) ? 15'($urandom_range(0, 12)) : 15'($urandom);
        ma_r = ($urandom_range(0, 99) < p_act);
        ms_r = 1'($urandom_range(0, 1));
        md_r = 1'($urandom_range(0, 1));
        pc_r = ($urandom_range(0, 49) == 0);
        model_step(we_r, st_r, dv_r, ma_r, ms_r, md_r, pc_r);
        drive(we_r, st_r, dv_r, ma_r, ms_r, md_r, pc_r);
        model_check();
      end
      $display("random block %0d: level=%0d ovf=%0d pos=%0d", blk, level, overflow, position);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
